// File: rtl/addr_seq_pkg.sv
// addr_seq_pkg: addressing modes, sequencer states and mode decoding shared with the CPU controller
package addr_seq_pkg;
  typedef enum logic [3:0] {
    IMM = 4'd0, ZP = 4'd1, ZPX = 4'd2, ZPY = 4'd3, ABS = 4'd4,
    ABSX = 4'd5, ABSY = 4'd6, INDX = 4'd7, INDY = 4'd8, IND = 4'd9
  } mode_t;
  typedef enum logic [2:0] {IDLE, OPL, OPH, IDX, PTRL, PTRH, FIX, DONE} state_t;
  function automatic mode_t to_mode(logic [3:0] m);
    return (m > 4'd9) ? IMM : mode_t'(m);
  endfunction
  function automatic logic is_indexed(mode_t m);
    return m inside {ABSX, ABSY, INDY};
  endfunction
endpackage

// File: rtl/addr_seq_if.sv
// addr_seq_if: bus between the CPU controller (master) and the address sequencer (slave)
interface addr_seq_if #(parameter int DATA_W = 8, parameter int ADDR_W = 16);
  logic ready, start, is_store, pc_inc, busy, done, page_cross;
  logic [3:0] mode;
  logic [DATA_W-1:0] index, d_in;
  logic [ADDR_W-1:0] pc, addr, ea;
  modport master (
    output ready, start, mode, is_store, index, pc, d_in,
    input addr, pc_inc, busy, done, ea, page_cross
  );
  modport slave (
    input ready, start, mode, is_store, index, pc, d_in,
    output addr, pc_inc, busy, done, ea, page_cross
  );
endinterface

// File: rtl/addr_seq_add.sv
// addr_seq_add: DATA_W adder with carry in/out shared across sequencer states
module addr_seq_add #(parameter int W = 8) (
  input logic [W-1:0] a,
  input logic [W-1:0] b,
  input logic ci,
  output logic [W-1:0] s,
  output logic co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/addr_seq.sv
// addr_seq: 6502-class effective-address sequencer walking operand and pointer fetch cycles
module addr_seq import addr_seq_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2 * DATA_W,
  parameter bit ZP_WRAP = 1'b1,
  parameter bit STORE_FIX = 1'b1,
  parameter bit JMP_IND_BUG = 1'b1
) (
  input logic clk,
  input logic reset,
  addr_seq_if.slave bus
);
  if (ADDR_W != 2 * DATA_W) begin : g_width_chk
    $error("addr_seq: ADDR_W must equal 2*DATA_W");
  end
  state_t state, nxt;
  mode_t m_q, m_in;
  logic st_q, carry, add_ci, add_co, fix, wrap;
  logic [DATA_W-1:0] lo, hi, ptr, idx, add_a, add_b, add_s, ptrh_hi;
  logic [ADDR_W-1:0] ea_q;
  assign m_in = to_mode(bus.mode);
  assign fix = carry | (st_q & STORE_FIX);
  assign wrap = (m_q == IND) ? JMP_IND_BUG : ZP_WRAP;
  assign ptrh_hi = wrap ? hi : hi + DATA_W'(add_co);
  assign add_a = (state == IDX) ? ((m_q == INDX) ? ptr : lo) :
                 (state == PTRH) ? ((m_q == IND) ? lo : ptr) :
                 (state == FIX) ? hi : bus.d_in;
  assign add_b = (state == PTRH || state == FIX) ? '0 : idx;
  assign add_ci = (state == PTRH) ? 1'b1 : (state == FIX) ? carry : 1'b0;
  addr_seq_add #(.W(DATA_W)) u_add (
    .a(add_a),
    .b(add_b),
    .ci(add_ci),
    .s(add_s),
    .co(add_co)
  );
  // state register; RDY low freezes the walk, reset wins over everything
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (bus.ready) state <= nxt;
  // next state: per-mode path through the fetch cycles
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = bus.start ? ((m_in == IMM) ? DONE : OPL) : IDLE;
      OPL: nxt = (m_q == ZP) ? DONE : (m_q inside {ZPX, ZPY, INDX}) ? IDX : (m_q == INDY) ? PTRL : OPH;
      OPH: nxt = (m_q == IND) ? PTRL : (m_q != ABS && fix) ? FIX : DONE;
      IDX: nxt = (m_q == INDX) ? PTRL : DONE;
      PTRL: nxt = PTRH;
      PTRH: nxt = (m_q == INDY && fix) ? FIX : DONE;
      FIX: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // outputs: bus address per state, pulses gated by RDY, ea live in DONE then held
  always_comb begin
    case (state)
      OPL, OPH: bus.addr = bus.pc;
      IDX: bus.addr = {{DATA_W{1'b0}}, ((m_q == INDX) ? ptr : lo)};
      PTRL: bus.addr = (m_q == IND) ? {hi, lo} : {hi, ptr};
      PTRH: bus.addr = {ptrh_hi, add_s};
      FIX: bus.addr = {hi, lo};
      default: bus.addr = '0;
    endcase
    bus.pc_inc = bus.ready & ((state == IDLE && bus.start && m_in == IMM) || state == OPL || state == OPH);
    bus.busy = state != IDLE;
    bus.done = bus.ready & (state == DONE);
    bus.ea = (state == DONE) ? {hi, lo} : ea_q;
    bus.page_cross = (state == DONE) && carry && is_indexed(m_q);
  end
  // datapath: operand/pointer bytes captured on each fetch; start latches the request
  always_ff @(posedge clk)
    if (reset) begin
      m_q <= IMM;
      st_q <= 1'b0;
      idx <= '0;
      lo <= '0;
      hi <= '0;
      ptr <= '0;
      carry <= 1'b0;
      ea_q <= '0;
    end else if (bus.ready)
      case (state)
        IDLE:
          if (bus.start) begin
            m_q <= m_in;
            st_q <= bus.is_store;
            idx <= bus.index;
            ptr <= '0;
            carry <= 1'b0;
            {hi, lo} <= (m_in == IMM) ? bus.pc : '0;
          end
        OPL:
          if (m_q inside {ABSX, ABSY}) {carry, lo} <= {add_co, add_s};
          else if (m_q inside {INDX, INDY}) ptr <= bus.d_in;
          else lo <= bus.d_in;
        OPH: hi <= bus.d_in;
        IDX: begin
          if (m_q == INDX) ptr <= add_s;
          else lo <= add_s;
          if (!ZP_WRAP) hi <= hi + DATA_W'(add_co);
        end
        PTRL:
          if (m_q == IND) ptr <= bus.d_in;
          else if (m_q == INDX) lo <= bus.d_in;
          else {carry, lo} <= {add_co, add_s};
        PTRH: begin
          hi <= bus.d_in;
          if (m_q == IND) lo <= ptr;
        end
        FIX: hi <= add_s;
        DONE: ea_q <= {hi, lo};
        default: ;
      endcase
endmodule

// File: tb/tb_addr_seq.sv
// tb_addr_seq: directed checks of two sequencer configurations sharing one memory model
module tb_addr_seq;
  logic clk, reset, ready, start, is_store;
  logic [3:0] mode;
  logic [7:0] index;
  logic [15:0] pc;
  logic [7:0] mem [0:65535];
  int checks = 0, errors = 0;
  int lat_a, lat_b, pi_a, pi_b;
  logic [15:0] ea_a, ea_b;
  logic pg_a, pg_b;
  logic [15:0] ad_a [0:31];
  logic [15:0] ad_b [0:31];
  addr_seq_if #(.DATA_W(8), .ADDR_W(16)) ua ();
  addr_seq_if #(.DATA_W(8), .ADDR_W(16)) ub ();
  assign ua.ready = ready;
  assign ua.start = start;
  assign ua.mode = mode;
  assign ua.is_store = is_store;
  assign ua.index = index;
  assign ua.pc = pc;
  assign ua.d_in = mem[ua.addr];
  assign ub.ready = ready;
  assign ub.start = start;
  assign ub.mode = mode;
  assign ub.is_store = is_store;
  assign ub.index = index;
  assign ub.pc = pc;
  assign ub.d_in = mem[ub.addr];
  addr_seq u_dut_a (.clk(clk), .reset(reset), .bus(ua));
  addr_seq #(.ZP_WRAP(1'b0), .STORE_FIX(1'b0), .JMP_IND_BUG(1'b0)) u_dut_b (.clk(clk), .reset(reset), .bus(ub));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] m, input logic s, input logic [7:0] x, input logic [15:0] p, input int sa, input int sl);
    logic inc;
    @(negedge clk);
    mode = m;
    is_store = s;
    index = x;
    pc = p;
    start = 1'b1;
    #1;
    pi_a = int'(ua.pc_inc);
    pi_b = int'(ub.pc_inc);
    lat_a = 0;
    lat_b = 0;
    inc = ua.pc_inc;
    @(negedge clk);
    start = 1'b0;
    if (inc) pc = pc + 16'd1;
    for (int c = 1; c <= 24 && (lat_a == 0 || lat_b == 0); c++) begin
      ready = !(c >= sa && c < sa + sl);
      #1;
      ad_a[c] = ua.addr;
      ad_b[c] = ub.addr;
      pi_a += int'(ua.pc_inc);
      pi_b += int'(ub.pc_inc);
      if (lat_a == 0 && ua.done) begin
        lat_a = c;
        ea_a = ua.ea;
        pg_a = ua.page_cross;
      end
      if (lat_b == 0 && ub.done) begin
        lat_b = c;
        ea_b = ub.ea;
        pg_b = ub.page_cross;
      end
      inc = ua.pc_inc;
      @(negedge clk);
      if (inc) pc = pc + 16'd1;
    end
    ready = 1'b1;
  endtask
  initial begin
    reset = 1'b1;
    ready = 1'b1;
    start = 1'b0;
    is_store = 1'b0;
    mode = 4'd0;
    index = 8'd0;
    pc = 16'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_addr", ua.addr, 16'h0000);
    check("rst_pc_inc", ua.pc_inc, 1'b0);
    check("rst_busy", ua.busy, 1'b0);
    check("rst_done", ua.done, 1'b0);
    check("rst_ea", ua.ea, 16'h0000);
    check("rst_page_cross", ua.page_cross, 1'b0);
    check("rst_busy_b", ub.busy, 1'b0);
    reset = 1'b0;
    run(4'd0, 1'b0, 8'h00, 16'h0700, 0, 0);
    check("imm_lat", lat_a, 1);
    check("imm_ea", ea_a, 16'h0700);
    check("imm_pc_inc", pi_a, 1);
    run(4'd15, 1'b0, 8'h00, 16'h0900, 0, 0);
    check("mode15_lat", lat_a, 1);
    check("mode15_ea", ea_a, 16'h0900);
    mem[16'h0800] = 8'h42;
    run(4'd1, 1'b0, 8'h00, 16'h0800, 0, 0);
    check("zp_lat", lat_a, 2);
    check("zp_ea", ea_a, 16'h0042);
    mem[16'h0200] = 8'hF8;
    run(4'd2, 1'b0, 8'h10, 16'h0200, 0, 0);
    check("zpx_lat", lat_a, 3);
    check("zpx_ea_wrap", ea_a, 16'h0008);
    check("zpx_pg", pg_a, 1'b0);
    check("zpx_ea_nowrap", ea_b, 16'h0108);
    check("zpx_pc_inc", pi_a, 1);
    mem[16'h8000] = 8'hF0;
    mem[16'h8001] = 8'h12;
    run(4'd5, 1'b0, 8'h20, 16'h8000, 0, 0);
    check("absx_cross_lat", lat_a, 4);
    check("absx_cross_ea", ea_a, 16'h1310);
    check("absx_cross_pg", pg_a, 1'b1);
    check("absx_cross_pc_inc", pi_a, 2);
    check("absx_cross_ea_b", ea_b, 16'h1310);
    run(4'd5, 1'b0, 8'h05, 16'h8000, 0, 0);
    check("absx_nocross_lat", lat_a, 3);
    check("absx_nocross_ea", ea_a, 16'h12F5);
    check("absx_nocross_pg", pg_a, 1'b0);
    run(4'd5, 1'b1, 8'h05, 16'h8000, 0, 0);
    check("absx_store_fix_lat", lat_a, 4);
    check("absx_store_fix_ea", ea_a, 16'h12F5);
    check("absx_store_nofix_lat", lat_b, 3);
    check("absx_store_pg", pg_a, 1'b0);
    mem[16'h0300] = 8'hFF;
    mem[16'h00FF] = 8'h80;
    mem[16'h0000] = 8'h40;
    mem[16'h0100] = 8'h50;
    run(4'd8, 1'b0, 8'h90, 16'h0300, 0, 0);
    check("indy_ptrh_addr", ad_a[3], 16'h0000);
    check("indy_ea", ea_a, 16'h4110);
    check("indy_lat", lat_a, 5);
    check("indy_pg", pg_a, 1'b1);
    check("indy_ptrh_addr_nowrap", ad_b[3], 16'h0100);
    check("indy_ea_nowrap", ea_b, 16'h5110);
    mem[16'h0400] = 8'hFF;
    mem[16'h0401] = 8'h30;
    mem[16'h30FF] = 8'h34;
    mem[16'h3000] = 8'h12;
    mem[16'h3100] = 8'h56;
    run(4'd9, 1'b0, 8'h00, 16'h0400, 0, 0);
    check("ind_ea_bug", ea_a, 16'h1234);
    check("ind_ea_nobug", ea_b, 16'h5634);
    check("ind_lat", lat_a, 5);
    check("ind_pg", pg_a, 1'b0);
    mem[16'h0500] = 8'h20;
    mem[16'h0024] = 8'h78;
    mem[16'h0025] = 8'h56;
    run(4'd7, 1'b0, 8'h04, 16'h0500, 3, 3);
    check("indx_stall_addr0", ad_a[3], 16'h0024);
    check("indx_stall_addr2", ad_a[5], 16'h0024);
    check("indx_resume_addr", ad_a[6], 16'h0024);
    check("indx_stall_lat", lat_a, 8);
    check("indx_stall_pc_inc", pi_a, 1);
    check("indx_stall_ea", ea_a, 16'h5678);
    mem[16'h0600] = 8'h34;
    mem[16'h0601] = 8'h12;
    @(negedge clk);
    mode = 4'd4;
    is_store = 1'b0;
    pc = 16'h0600;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    pc = 16'h0601;
    #1;
    check("abs_oph_busy", ua.busy, 1'b1);
    check("abs_oph_addr", ua.addr, 16'h0601);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    #1;
    check("rst_mid_busy", ua.busy, 1'b0);
    check("rst_mid_ea", ua.ea, 16'h0000);
    check("rst_mid_done", ua.done, 1'b0);
    @(negedge clk);
    #1;
    check("rst_start_ignored", ua.busy, 1'b0);
    run(4'd4, 1'b0, 8'h00, 16'h0600, 0, 0);
    check("abs_lat", lat_a, 3);
    check("abs_ea", ea_a, 16'h1234);
    check("abs_pc_inc", pi_a, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_seq.md
# addr_seq

Parametrised effective-address sequencer for the 6502-class CPU core. It takes an addressing mode, an index value and the current PC, and walks the operand and pointer fetch cycles on the CPU bus. It then presents the final effective address with a page-cross flag. It replaces the per-mode address states hard-coded in the CPU controller, and adds ZP,Y, JMP-indirect, RDY stall and a configurable store fix-up cycle.

## Interface
- DATA_W, 8, data bus width; ADDR_W = 2*DATA_W is required (elaboration error otherwise)
- ZP_WRAP, 1, 1: zero-page index/pointer arithmetic wraps within page 0; 0: carry propagates into the high byte
- STORE_FIX, 1, 1: indexed stores (ABSX/ABSY/INDY) always take the FIX cycle
- JMP_IND_BUG, 1, 1: IND high-pointer fetch wraps within the page (NMOS behaviour)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- ready  in  1  RDY; low freezes all state and outputs
- start  in  1  request; sampled only in IDLE with ready high
- mode  in  4  IMM=0, ZP=1, ZPX=2, ZPY=3, ABS=4, ABSX=5, ABSY=6, INDX=7, INDY=8, IND=9; others treated as IMM
- is_store  in  1  qualifies STORE_FIX
- index  in  DATA_W  X or Y value, captured at start
- pc  in  ADDR_W  current program counter
- d_in  in  DATA_W  read data, valid in the same cycle that addr is driven
- addr  out  ADDR_W  bus address
- pc_inc  out  1  one-cycle pulse; consumer increments PC
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; ea is valid
- ea  out  ADDR_W  effective address, held until the next start
- page_cross  out  1  valid with done; high when an index add carried out of the low byte

## Operation
- States: IDLE, OPL, OPH, IDX, PTRL, PTRH, FIX, DONE. Internal registers: lo, hi, ptr, idx, carry.
- Mode and is_store are latched at start. idx is latched from index at start.
- OPL: addr=pc, pc_inc=1.
  - ZP/ZPX/ZPY/ABS/IND: lo<=d_in.
  - ABSX/ABSY: {carry,lo}<=d_in+idx.
  - INDX/INDY: ptr<=d_in.
- OPH: addr=pc, pc_inc=1, hi<=d_in.
- IDX: dummy read at addr={0,ptr_or_lo}.
  - INDX: ptr<=ptr+idx.
  - ZPX/ZPY: lo<=lo+idx.
  - The add wraps mod 2^DATA_W when ZP_WRAP=1; when ZP_WRAP=0, the carry goes to hi.
- PTRL:
  - INDX/INDY: addr={0,ptr}. INDX: lo<=d_in. INDY: {carry,lo}<=d_in+idx.
  - IND: addr={hi,lo}, ptr<=d_in.
- PTRH, hi<=d_in in all modes:
  - INDX/INDY: addr={0,ptr+1}, which wraps in page 0 when ZP_WRAP=1.
  - IND: addr={hi,lo+1} when JMP_IND_BUG=1, else {hi,lo}+1.
  - IND additionally sets lo<=ptr at this edge.
- FIX: dummy read at {hi,lo}; hi<=hi+carry.
- DONE: ea is driven and done=1. The next state is IDLE.
- Transitions per mode:
  - IMM: IDLE→DONE, with ea=pc and pc_inc pulsed on the IDLE cycle.
  - ZP: OPL→DONE.
  - ZPX/ZPY: OPL→IDX→DONE.
  - ABS: OPL→OPH→DONE.
  - ABSX/ABSY: OPL→OPH→(FIX if carry or (is_store and STORE_FIX))→DONE.
  - INDX: OPL→IDX→PTRL→PTRH→DONE.
  - INDY: OPL→PTRL→PTRH→(FIX condition as ABSX)→DONE.
  - IND: OPL→OPH→PTRL→PTRH→DONE.
- page_cross = carry for ABSX/ABSY/INDY, and 0 for all other modes.
- start while busy is ignored. No queueing.

## Timing
- Reset values: addr=0, pc_inc=0, busy=0, done=0, ea=0, page_cross=0; state=IDLE. All internal registers are cleared.
- Latency from the start edge to done, in cycles: IMM 1, ZP 2, ZPX/ZPY 3, ABS 3, ABSX/ABSY 3 or 4, INDX 5, INDY 4 or 5, IND 5.
- ready low:
  - No state or register update.
  - addr holds its value.
  - pc_inc and done are forced to 0.
  - When ready returns high, the held cycle repeats.
- reset in any state returns the block to IDLE at that edge, overriding ready and start.
- A new start is accepted on the cycle after DONE. Back-to-back sequences have no gap beyond the IDLE cycle.
- addr is combinational from state and registers. pc_inc, done and ea are registered/state-decoded and glitch-free at the edge.

## Structure
- Package addr_seq_pkg: the mode enum (4-bit) and the state enum, shared with the CPU controller.
- One sub-module, addr_seq_add: a DATA_W adder with carry-in and carry-out, instanced once and muxed per state.
- No memories. Pure FSM plus datapath.

## Test plan
- ZPX, X=0x10, operand 0xF8, ZP_WRAP=1: done after 3 cycles, ea=0x0008, page_cross=0. With ZP_WRAP=0: ea=0x0108.
- ABSX load at pc=0x8000 with bytes 0xF0,0x12 and X=0x20: IDLE→OPL→OPH→FIX→DONE, ea=0x1310, page_cross=1, pc_inc pulsed twice. With X=0x05: no FIX, ea=0x12F5.
- INDY, operand 0xFF, mem[0x00FF]=0x80, mem[0x0000]=0x40, Y=0x90: PTRH addr=0x0000, ea=0x4110, latency 5.
- IND, bytes 0xFF,0x30, mem[0x30FF]=0x34, mem[0x3000]=0x12 (JMP_IND_BUG=1): ea=0x1234. With JMP_IND_BUG=0, mem[0x3100]=0x56: ea=0x5634.
- ready held low for 3 cycles during INDX PTRL: addr is stable at {0,ptr}, no pc_inc or done, and latency grows by exactly 3.
- Reset asserted in OPH of ABS: the next cycle shows busy=0, ea=0, state IDLE. A start issued in the same cycle as reset is ignored.
